// File: rtl/truth_table_sweeper.sv
// Sequential stimulus/response engine: sweeps every input vector into a combinational DUT,
// captures its output as a minterm mask and compares it against a latched golden mask.
// Optional macro TT_FIRST_FAIL_EN builds the first-failing-index registers.

module truth_table_sweeper #(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_s,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   captured,
    output logic                 match,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic                 fail_valid
);

    localparam int unsigned NVec = 2**N_IN;
    localparam int unsigned CtrW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CtrW-1:0]   ctr_q, ctr_d;
    logic [NVec-1:0]   exp_q, exp_d;
    logic [NVec-1:0]   cap_q, cap_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              match_q, match_d;
    logic              mism;
`ifdef TT_FIRST_FAIL_EN
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              fv_q, fv_d;
`endif

    assign mism = (dut_s != exp_q[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ctr_d   = ctr_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        match_d = match_q;
`ifdef TT_FIRST_FAIL_EN
        ff_d    = ff_q;
        fv_d    = fv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    exp_d   = expected;
                    cap_d   = '0;
                    cnt_d   = '0;
                    match_d = 1'b0;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    ctr_d   = '0;
`ifdef TT_FIRST_FAIL_EN
                    ff_d    = '0;
                    fv_d    = 1'b0;
`endif
                    state_d = StSettle;
                end
            end
            StSettle: begin
                ctr_d = ctr_q + CtrW'(1);
                if (ctr_q == CtrW'(SETTLE_CYC - 1)) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                cap_d[vec_q] = dut_s;
                if (mism) begin
                    cnt_d = cnt_q + (N_IN+1)'(1);
`ifdef TT_FIRST_FAIL_EN
                    // Only the lowest failing index is kept.
                    if (!fv_q) begin
                        ff_d = vec_q;
                        fv_d = 1'b1;
                    end
`endif
                end
                if (vec_q == {N_IN{1'b1}}) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    ctr_d   = '0;
                    state_d = StSettle;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                match_d = (cnt_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            ctr_q   <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ctr_q   <= ctr_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

`ifdef TT_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q <= '0;
            fv_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
            fv_q <= fv_d;
        end
    end

    assign first_fail = ff_q;
    assign fail_valid = fv_q;
`else
    assign first_fail = '0;
    assign fail_valid = 1'b0;
`endif

    assign vec_out      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign captured     = cap_q;
    assign match        = match_q;
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper (N_IN=4, SETTLE_CYC=1).
// The DUT under sweep is a truth-table lookup; expectations come from mask arithmetic.

module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected = '0;
    logic [15:0] tt = '0;
    logic        dut_s;
    logic [3:0]  vec_out;
    logic        busy, done, match, fail_valid;
    logic [15:0] captured;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;

    int checks = 0;
    int errors = 0;

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .expected     (expected),
        .dut_s        (dut_s),
        .vec_out      (vec_out),
        .busy         (busy),
        .done         (done),
        .captured     (captured),
        .match        (match),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail),
        .fail_valid   (fail_valid)
    );

    assign dut_s = tt[vec_out];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lowest_set(input logic [15:0] x);
        for (int i = 0; i < 16; i++) begin
            if (x[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic logic [15:0] mask_of(input int fn);
        logic [15:0] m;
        logic a, b, c, d;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            a = i[3]; b = i[2]; c = i[1]; d = i[0];
            case (fn)
                0: m[i] = (i == 0) || (i == 1) || (i == 2) || (i == 3) || (i == 5) ||
                          (i == 8) || (i == 13);
                1: m[i] = !(a || b || c || d);
                default: m[i] = !(a && b && c && d);
            endcase
        end
        return m;
    endfunction

    task automatic check_results(input string tag, input logic [15:0] ttv,
                                 input logic [15:0] exv);
        check({tag, " captured"}, captured, ttv);
        check({tag, " match"}, match, ttv == exv);
        check({tag, " mismatch_cnt"}, mismatch_cnt, $countones(ttv ^ exv));
        check({tag, " vec_out"}, vec_out, 4'hF);
`ifdef TT_FIRST_FAIL_EN
        check({tag, " fail_valid"}, fail_valid, ttv != exv);
        check({tag, " first_fail"}, first_fail, lowest_set(ttv ^ exv));
`else
        check({tag, " fail_valid"}, fail_valid, 1'b0);
        check({tag, " first_fail"}, first_fail, 4'd0);
`endif
    endtask

    // Called at the first negedge after the accepting edge; returns at the done negedge.
    task automatic wait_done(input string tag, input int dist_vec, input logic [15:0] dist_exp);
        int  lat;
        bit  did, pulse_on, busy_bad;
        lat = 0; did = 0; pulse_on = 0; busy_bad = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad = 1;
            @(negedge clk);
            lat++;
            if (pulse_on) begin
                start = 1'b0;
                pulse_on = 0;
            end
            if (dist_vec >= 0 && !did && int'(vec_out) == dist_vec) begin
                start = 1'b1;
                expected = dist_exp;
                did = 1;
                pulse_on = 1;
            end
        end
        check({tag, " latency"}, lat, 33);
        check({tag, " busy during sweep"}, busy_bad, 0);
        check({tag, " busy at done"}, busy, 1'b0);
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] ttv, input logic [15:0] exv,
                             input int dist_vec);
        int extra;
        @(negedge clk);
        tt = ttv;
        expected = exv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " vec_out at accept"}, vec_out, 4'd0);
        wait_done(tag, dist_vec, ~exv);
        check_results(tag, ttv, exv);
        @(negedge clk);
        check({tag, " done pulse width"}, done, 1'b0);
        if (dist_vec >= 0) begin
            extra = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check({tag, " extra done"}, extra, 0);
            check_results({tag, " held"}, ttv, exv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " vec_out"}, vec_out, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " captured"}, captured, 0);
        check({tag, " match"}, match, 0);
        check({tag, " mismatch_cnt"}, mismatch_cnt, 0);
        check({tag, " first_fail"}, first_fail, 0);
        check({tag, " fail_valid"}, fail_valid, 0);
    endtask

    initial begin
        logic [15:0] sop, nor_m, nand_m, r_tt, r_ex;
        int guard;
        sop    = mask_of(0);
        nor_m  = mask_of(1);
        nand_m = mask_of(2);

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run_sweep("sop", sop, 16'h212F, -1);
        run_sweep("tie0", 16'h0000, 16'h212F, -1);
        run_sweep("tie1", 16'hFFFF, 16'h212F, -1);

        // Reset mid-sweep at vec_out==6.
        @(negedge clk);
        tt = 16'hA5C3;
        expected = 16'h212F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (vec_out !== 4'd6 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reach vec 6", vec_out, 4'd6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("midreset");
        run_sweep("after reset", 16'h5A3C, 16'h5A3C, -1);

        run_sweep("restart ignored", sop, 16'h212F, 3);

        // Back-to-back sweeps with start held high.
        @(negedge clk);
        tt = nor_m;
        expected = nor_m;
        start = 1'b1;
        @(negedge clk);
        wait_done("nor", -1, 16'h0);
        check_results("nor", nor_m, nor_m);
        tt = nand_m;
        expected = 16'h7FFE;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", busy, 1'b1);
        check("b2b captured cleared", captured, 16'h0);
        check("b2b cnt cleared", mismatch_cnt, 0);
        wait_done("nand", -1, 16'h0);
        check_results("nand", nand_m, 16'h7FFE);

        for (int n = 0; n < 6; n++) begin
            r_tt = 16'($urandom);
            r_ex = (n % 3 == 0) ? r_tt : 16'($urandom);
            run_sweep($sformatf("rand%0d", n), r_tt, r_ex, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
